ff_updown_counter: RTL
======================

Name: ff_updown_counter

Overview:
- Parametrised successor to the 4-bit clear/plus flip-flop counter: WIDTH-bit up/down counter with a configurable step, synchronous load, wrap or saturate mode, a registered terminal-count pulse and a sticky overflow flag.
- Count state is held in an explicit bank of FDCE primitives with async clear driven from reset.
- The next-state value is exported so that netlist-comparison flows can observe the D inputs.

Parameters:
WIDTH, 4, counter width in bits (2..32)
STEP, 1, increment/decrement magnitude; must be 1..2^WIDTH-1
SATURATE, 0, 0 = modulo wrap, 1 = clamp at 0 / 2^WIDTH-1
RESET_VAL, 0, value loaded by the synchronous clear and by reset

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
clear  input  1  synchronous clear to RESET_VAL
load  input  1  synchronous load of load_val
load_val  input  WIDTH  value to load
plus  input  1  count up by STEP
minus  input  1  count down by STEP
Q  output  WIDTH  registered count
input_ff  output  WIDTH  combinational next-state value (D of the FF bank)
tc  output  1  registered one-cycle pulse: count wrapped or hit a limit this step
ovf  output  1  sticky overflow/underflow flag

Behaviour:
- Reset (rst_n=0, async): Q=RESET_VAL, tc=0, ovf=0. Release is synchronous to clk; first update occurs on the first edge with rst_n=1.
- Next-state priority, evaluated per cycle:
  1. clear=1 with plus=minus=0: input_ff=RESET_VAL.
  2. clear=1 with plus or minus: hold. This is the legacy conflict rule and is intentional.
  3. load=1: input_ff=load_val. Load wins over plus/minus.
  4. plus=1 and minus=0: count up.
  5. minus=1 and plus=0: count down.
  6. Otherwise (none asserted, or plus=minus=1): hold.
- Arithmetic:
  - Computed in WIDTH+1 bits.
  - Up: sum=Q+STEP; carry when sum>2^WIDTH-1.
  - Down: borrow when Q<STEP.
  - Wrap (SATURATE=0): input_ff=sum mod 2^WIDTH.
  - Saturate (SATURATE=1): on carry input_ff=2^WIDTH-1; on borrow input_ff=0.
- Terminal count:
  - Internal event evt = carry or borrow on an accepted count step.
  - In saturate mode, evt also fires when a step is requested while already at the limit in that direction.
  - tc is registered: tc=evt on the following edge, then deasserts unless evt recurs. Back-to-back events give a continuous tc high.
- ovf: set on the edge that registers evt. Cleared only by reset or an accepted clear (priority case 1). Load does not clear it.
- Latency:
  - Q updates on the edge after inputs are sampled.
  - tc and ovf become visible on the same edge as the Q update that caused them.
- Reset mid-count: all state returns to reset values immediately; no pending tc survives.
- input_ff is purely combinational from Q and the control inputs, with no loops.

Decomposition:
- Package ff_counter_pkg:
  - typedef enum {OP_HOLD, OP_CLEAR, OP_LOAD, OP_UP, OP_DOWN} counter_op_t
  - function decode_op(clear, load, plus, minus) returning counter_op_t
- Sub-module ff_bank (WIDTH): generate loop of FDCE with C=clk, CE=1'b1, CLR=~rst_n, D=d[i], Q=q[i].
  - ff_bank holds Q only.
  - tc and ovf are ordinary always_ff registers in the top module.

Test Plan:
1. WIDTH=4, STEP=1, SATURATE=0: reset, then plus for 16 cycles. Q steps 1..15 then 0; tc=1 only in the cycle Q shows 0; ovf=1 afterwards.
2. SATURATE=1: load 4'hE, then plus for 3 cycles. Q=F,F,F; tc=1 on the 2nd and 3rd Q updates; ovf=1. Then minus from load 4'h1 with STEP=3 gives Q=0.
3. Priority: clear=1 & plus=1 with Q=5 gives Q=5 (hold). clear alone gives Q=RESET_VAL and ovf=0. load=1 & plus=1 with load_val=9 gives Q=9. plus=minus=1 gives hold.
4. STEP=3, WIDTH=4, wrap mode: from Q=14, plus gives Q=1 and tc pulse. From Q=1, minus gives Q=14 and tc pulse.
5. Async reset: assert rst_n=0 mid-count between clock edges. Q, tc and ovf go to reset values without waiting for clk; counting resumes from RESET_VAL one edge after release.
6. input_ff check: with Q=7, plus=1, input_ff=8 before the edge and Q=8 after it. Holds across all op codes and matches the reference model every cycle in a random 1000-cycle run.

Source files
------------

// File: rtl/ff_counter_pkg.sv
// rtl/ff_counter_pkg.sv - shared op encoding and control decode for the up/down counter
package ff_counter_pkg;

  typedef enum logic [2:0] {
    OP_HOLD,
    OP_CLEAR,
    OP_LOAD,
    OP_UP,
    OP_DOWN
  } counter_op_t;

  // Legacy rule: clear together with a count request freezes the counter.
  function automatic counter_op_t decode_op(input logic clear, input logic load,
                                            input logic plus, input logic minus);
    counter_op_t op;
    op = OP_HOLD;
    if (clear) begin
      op = (plus || minus) ? OP_HOLD : OP_CLEAR;
    end else if (load) begin
      op = OP_LOAD;
    end else if (plus && !minus) begin
      op = OP_UP;
    end else if (minus && !plus) begin
      op = OP_DOWN;
    end
    return op;
  endfunction

endpackage

// File: rtl/FDCE.sv
// rtl/FDCE.sv - behavioural D flip-flop with clock enable and async clear
module FDCE (
  input  logic C,
  input  logic CE,
  input  logic CLR,
  input  logic D,
  output logic Q
);

  // Clear dominates asynchronously; otherwise capture D when enabled.
  always_ff @(posedge C or posedge CLR) begin
    if (CLR) begin
      Q <= 1'b0;
    end else if (CE) begin
      Q <= D;
    end
  end

endmodule

// File: rtl/ff_updown_counter_bank.sv
// rtl/ff_updown_counter_bank.sv - WIDTH-bit bank of always-enabled FDCE cells
module ff_bank #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic clr;

  assign clr = ~rst_n;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    FDCE u_ff (
      .C  (clk),
      .CE (1'b1),
      .CLR(clr),
      .D  (d[i]),
      .Q  (q[i])
    );
  end

endmodule

// File: rtl/ff_updown_counter.sv
// rtl/ff_updown_counter.sv - parametrised up/down counter with load, wrap/saturate, tc and sticky ovf
module ff_updown_counter
  import ff_counter_pkg::*;
#(
  parameter int                WIDTH     = 4,
  parameter int unsigned       STEP      = 1,
  parameter bit                SATURATE  = 1'b0,
  parameter logic [WIDTH-1:0]  RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             plus,
  input  logic             minus,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] input_ff,
  output logic             tc,
  output logic             ovf
);

  localparam int XW = WIDTH + 1;
  localparam logic [WIDTH:0] STEP_X = XW'(STEP);

  counter_op_t      op;
  logic [WIDTH:0]   q_x;
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   diff;
  logic             carry;
  logic             borrow;
  logic             evt;
  logic [WIDTH-1:0] bank_d;
  logic [WIDTH-1:0] bank_q;

  assign op     = decode_op(clear, load, plus, minus);
  assign q_x    = {1'b0, Q};
  assign sum    = q_x + STEP_X;
  assign diff   = q_x - STEP_X;
  // Both operands fit in WIDTH bits, so the extra bit is exactly carry / borrow.
  assign carry  = sum[WIDTH];
  assign borrow = diff[WIDTH];

  // Next-state selection and terminal-count event; saturation clamps give evt at the limit too.
  always_comb begin
    input_ff = Q;
    evt      = 1'b0;
    case (op)
      OP_CLEAR: input_ff = RESET_VAL;
      OP_LOAD:  input_ff = load_val;
      OP_UP: begin
        evt      = carry;
        input_ff = (carry && SATURATE) ? {WIDTH{1'b1}} : sum[WIDTH-1:0];
      end
      OP_DOWN: begin
        evt      = borrow;
        input_ff = (borrow && SATURATE) ? {WIDTH{1'b0}} : diff[WIDTH-1:0];
      end
      default: input_ff = Q;
    endcase
  end

  // The FDCE cells only clear to zero, so the bank stores the count XOR RESET_VAL;
  // a cleared bank then reads back as RESET_VAL.
  assign bank_d = input_ff ^ RESET_VAL;
  assign Q      = bank_q ^ RESET_VAL;

  ff_bank #(
    .WIDTH(WIDTH)
  ) u_bank (
    .clk  (clk),
    .rst_n(rst_n),
    .d    (bank_d),
    .q    (bank_q)
  );

  // Registered tc pulse and sticky ovf, cleared only by reset or an accepted clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tc  <= 1'b0;
      ovf <= 1'b0;
    end else begin
      tc <= evt;
      if (op == OP_CLEAR) begin
        ovf <= 1'b0;
      end else if (evt) begin
        ovf <= 1'b1;
      end
    end
  end

endmodule
